// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and its iterative
// multiply/divide unit. The DIV state only exists when ALU_CTRL_DIV_EN is
// defined.
package alu_ctrl_pkg;

  // Main-control aluOp field.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // R-type funct field values.
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_XOR   = 6'd38;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  // ALU operation codes (zero-extended to CTRL_W at the port).
  typedef enum logic [3:0] {
    CTL_AND  = 4'b0000,
    CTL_OR   = 4'b0001,
    CTL_ADD  = 4'b0010,
    CTL_SUB  = 4'b0110,
    CTL_SLT  = 4'b0111,
    CTL_NOR  = 4'b1100,
    CTL_XOR  = 4'b1101,
    CTL_SLTU = 4'b1111
  } alu_ctl_e;

  // EX result mux select.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_HI  = 2'b01;
  localparam logic [1:0] RES_LO  = 2'b10;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef ALU_CTRL_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one bit per step, shift-add multiply
// and restoring divide on operand magnitudes, sign fix-up on commit into
// HI/LO. The divider is only built when ALU_CTRL_DIV_EN is defined.
module mdu_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              signed_i,
`ifdef ALU_CTRL_DIV_EN
  input  logic              div_i,
`endif
  input  logic              step_i,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  // Upper half: product accumulator / partial remainder.
  // Lower half: multiplier / dividend shifting out, quotient shifting in.
  logic [2*DATA_W-1:0] p_q, p_d, p_init;
  logic [DATA_W-1:0]   m_q, m_init;
  logic                neg_q, neg_init;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod;
`ifdef ALU_CTRL_DIV_EN
  logic                div_q;
  logic                rem_neg_q, rem_neg_init;
  logic [DATA_W:0]     div_diff;
`endif

  // Strip operand signs at start so the core only ever sees magnitudes.
  always_comb begin
    a_neg    = signed_i & a_i[DATA_W-1];
    b_neg    = signed_i & b_i[DATA_W-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    p_init   = {{DATA_W{1'b0}}, b_mag};
    m_init   = a_mag;
    neg_init = a_neg ^ b_neg;
`ifdef ALU_CTRL_DIV_EN
    rem_neg_init = a_neg;
    if (div_i) begin
      p_init   = {{DATA_W{1'b0}}, a_mag};
      m_init   = b_mag;
      // A zero divisor yields an all-ones quotient that must not be negated.
      neg_init = (a_neg ^ b_neg) & (|b_i);
    end
`endif
  end

  // One iteration step and the sign-corrected results committed in DONE.
  always_comb begin
    mul_sum = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, m_q} : '0);
    p_d     = {mul_sum, p_q[DATA_W-1:1]};
    prod    = neg_q ? -p_q : p_q;
    hi_d    = prod[2*DATA_W-1:DATA_W];
    lo_d    = prod[DATA_W-1:0];
`ifdef ALU_CTRL_DIV_EN
    // Trial subtract of the divisor from {remainder, next dividend bit};
    // bit DATA_W of the difference is the borrow.
    div_diff = p_q[2*DATA_W-1:DATA_W-1] - {1'b0, m_q};
    if (div_q) begin
      p_d  = div_diff[DATA_W] ? {p_q[2*DATA_W-2:0], 1'b0}
                              : {div_diff[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
      hi_d = rem_neg_q ? -p_q[2*DATA_W-1:DATA_W] : p_q[2*DATA_W-1:DATA_W];
      lo_d = neg_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
    end
`endif
  end

  // Capture on start, iterate while stepping, write HI/LO on commit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q   <= '0;
      m_q   <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef ALU_CTRL_DIV_EN
      div_q     <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      if (start_i) begin
        p_q   <= p_init;
        m_q   <= m_init;
        neg_q <= neg_init;
        cnt_q <= '0;
`ifdef ALU_CTRL_DIV_EN
        div_q     <= div_i;
        rem_neg_q <= rem_neg_init;
`endif
      end else if (step_i) begin
        p_q   <= p_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (commit_i) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  assign last_o = step_i && (cnt_q == CNT_LAST);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decoder with an iterative multiply/divide unit.
// Decode is combinational; the MDU sequencer stalls the pipeline from the
// start cycle through DONE (DATA_W+2 cycles). Define ALU_CTRL_DIV_EN to
// build DIV/DIVU; otherwise those functs decode as illegal.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [1:0]        aluOp,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [CTRL_W-1:0] aluControl,
  output logic [1:0]        res_sel,
  output logic              illegal,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  alu_ctl_e   ctl;
  logic       bad_funct;
  logic       mdu_op;
  logic       mdu_signed;
  logic       mdu_start;
  logic       mdu_last;
  logic       mdu_step;
  logic       mdu_commit;
  mdu_state_e state_q, state_d;
`ifdef ALU_CTRL_DIV_EN
  logic       mdu_div;
`endif

  // Decode aluOp/funct into ALU code, result select and MDU request.
  // NOTE: every output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    ctl        = CTL_ADD;
    res_sel    = RES_ALU;
    bad_funct  = 1'b0;
    mdu_op     = 1'b0;
    mdu_signed = 1'b0;
`ifdef ALU_CTRL_DIV_EN
    mdu_div    = 1'b0;
`endif
    case (aluOp)
      ALUOP_ADD: ctl = CTL_ADD;
      ALUOP_SUB: ctl = CTL_SUB;
      ALUOP_OR:  ctl = CTL_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: ctl = CTL_ADD;
          FN_SUB, FN_SUBU: ctl = CTL_SUB;
          FN_AND:          ctl = CTL_AND;
          FN_OR:           ctl = CTL_OR;
          FN_XOR:          ctl = CTL_XOR;
          FN_NOR:          ctl = CTL_NOR;
          FN_SLT:          ctl = CTL_SLT;
          FN_SLTU:         ctl = CTL_SLTU;
          FN_MFHI:         res_sel = RES_HI;
          FN_MFLO:         res_sel = RES_LO;
          FN_MULT: begin
            mdu_op     = 1'b1;
            mdu_signed = 1'b1;
          end
          FN_MULTU:        mdu_op = 1'b1;
          FN_DIV, FN_DIVU: begin
`ifdef ALU_CTRL_DIV_EN
            mdu_op     = 1'b1;
            mdu_div    = 1'b1;
            mdu_signed = (funct == FN_DIV);
`else
            bad_funct  = 1'b1;
`endif
          end
          default:         bad_funct = 1'b1;
        endcase
      end
      default: ctl = CTL_ADD;
    endcase
  end

  assign aluControl = CTRL_W'(ctl);
  assign illegal    = valid && bad_funct;
  // Start is only sampled in IDLE; requests seen while busy just keep stalling.
  assign mdu_start  = valid && mdu_op && (state_q == ST_IDLE);

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, stall and datapath strobes.
  always_comb begin
    state_d    = state_q;
    stall      = 1'b1;
    mdu_step   = 1'b0;
    mdu_commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = mdu_start;
        if (mdu_start) begin
`ifdef ALU_CTRL_DIV_EN
          state_d = mdu_div ? ST_DIV : ST_MUL;
`else
          state_d = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        mdu_step = 1'b1;
        if (mdu_last) state_d = ST_DONE;
      end
`ifdef ALU_CTRL_DIV_EN
      ST_DIV: begin
        mdu_step = 1'b1;
        if (mdu_last) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        mdu_commit = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mdu_iter #(
    .DATA_W(DATA_W)
  ) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mdu_start),
    .signed_i (mdu_signed),
`ifdef ALU_CTRL_DIV_EN
    .div_i    (mdu_div),
`endif
    .step_i   (mdu_step),
    .commit_i (mdu_commit),
    .a_i      (rs_data),
    .b_i      (rt_data),
    .last_o   (mdu_last),
    .hi_o     (hi),
    .lo_o     (lo)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: decode sweep, directed and random
// multiply/divide against a 64-bit arithmetic reference, MFLO interlock and
// mid-operation reset. Honours ALU_CTRL_DIV_EN the same way as the RTL.
module tb_alu_ctrl_mdu;

`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [1:0]  aluOp;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic [3:0]  aluControl;
  logic [1:0]  res_sel;
  logic        illegal, stall;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .aluOp      (aluOp),
    .funct      (funct),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .aluControl (aluControl),
    .res_sel    (res_sel),
    .illegal    (illegal),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_ctrl(input int op, input int fn);
    if (op == 0) return 4'b0010;
    if (op == 1) return 4'b0110;
    if (op == 3) return 4'b0001;
    case (fn)
      32, 33:  return 4'b0010;
      34, 35:  return 4'b0110;
      36:      return 4'b0000;
      37:      return 4'b0001;
      38:      return 4'b1101;
      39:      return 4'b1100;
      42:      return 4'b0111;
      43:      return 4'b1111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit ref_is_mdu(input int fn);
    return (fn == 24) || (fn == 25) || (DIV_EN && (fn == 26 || fn == 27));
  endfunction

  function automatic bit ref_known(input int fn);
    return (fn >= 32 && fn <= 39) || fn == 42 || fn == 43 || fn == 16 || fn == 18
           || ref_is_mdu(fn);
  endfunction

  function automatic logic [1:0] ref_sel(input int op, input int fn);
    if (op == 2 && fn == 16) return 2'b01;
    if (op == 2 && fn == 18) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void ref_mdu(input int fn, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (fn)
      24: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      25: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
      26: if (b == 0) begin l = '1; h = a; end
          else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      27: if (b == 0) begin l = '1; h = a; end
          else begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  // Issue one MDU-class instruction for a single cycle and follow it to completion.
  task automatic run_op(input int fn, input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    bit          sup;
    logic [31:0] eh, el;
    sup = ref_is_mdu(fn);
    eh  = m_hi;
    el  = m_lo;
    if (sup) ref_mdu(fn, a, b, eh, el);
    @(negedge clk);
    valid = 1'b1; aluOp = 2'b10; funct = 6'(fn); rs_data = a; rt_data = b;
    #1;
    check($sformatf("start_illegal fn%0d", fn), illegal, !sup);
    cyc = 0;
    while (stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
      valid = 1'b0;
      #1;
    end
    valid = 1'b0;
    check($sformatf("stall_cycles fn%0d a=%h b=%h", fn, a, b), cyc, sup ? LAT : 0);
    check($sformatf("hi fn%0d a=%h b=%h", fn, a, b), hi, eh);
    check($sformatf("lo fn%0d a=%h b=%h", fn, a, b), lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] eh, el;

    // ---------------- reset ----------------
    reset = 1'b1; valid = 1'b0; aluOp = 2'b01; funct = '0; rs_data = '0; rt_data = '0;
    #1;
    check("reset_stall", stall, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_decode_follows", aluControl, ref_ctrl(1, 0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ---------------- decode sweep ----------------
    for (int op = 0; op < 4; op++) begin
      for (int fn = 0; fn < 64; fn++) begin
        if (op != 2 && (fn % 16) != 0) continue;
        @(negedge clk);
        aluOp = 2'(op); funct = 6'(fn); valid = 1'b1; rs_data = $urandom; rt_data = $urandom;
        #1;
        check($sformatf("dec_ctrl op%0d fn%0d", op, fn), aluControl, ref_ctrl(op, fn));
        check($sformatf("dec_sel op%0d fn%0d", op, fn), res_sel, ref_sel(op, fn));
        check($sformatf("dec_illegal op%0d fn%0d", op, fn), illegal,
              (op == 2) && !ref_known(fn));
        check($sformatf("dec_stall op%0d fn%0d", op, fn), stall,
              (op == 2) && ref_is_mdu(fn));
        valid = 1'b0;
        #1;
        check($sformatf("dec_illegal_inv op%0d fn%0d", op, fn), illegal, 1'b0);
        check($sformatf("dec_stall_inv op%0d fn%0d", op, fn), stall, 1'b0);
      end
    end

    // ---------------- directed multiply / divide ----------------
    run_op(24, 32'd7, 32'hFFFF_FFFD);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFEB);
    run_op(25, 32'd7, 32'hFFFF_FFFD);
    check("multu_hi_const", hi, 32'h0000_0006);
    check("multu_lo_const", lo, 32'hFFFF_FFEB);
    run_op(27, 32'd100, 32'd7);
    run_op(26, 32'hFFFF_FFF9, 32'd2);
    run_op(26, 32'd5, 32'd0);
    run_op(26, 32'hFFFF_FFFB, 32'd0);
    run_op(27, 32'hDEAD_BEEF, 32'd0);
    run_op(26, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(24, 32'h8000_0000, 32'h8000_0000);

    // ---------------- random multiply / divide ----------------
    for (int i = 0; i < 16; i++) run_op(24 + int'($urandom_range(0, 3)), pick(), pick());

    // ---------------- MFLO right behind MULT ----------------
    eh = m_hi; el = m_lo;
    ref_mdu(24, 32'd123457, 32'hFFFF_FF9D, eh, el);
    @(negedge clk);
    valid = 1'b1; aluOp = 2'b10; funct = 6'd24; rs_data = 32'd123457; rt_data = 32'hFFFF_FF9D;
    #1;
    check("mflo_start_stall", stall, 1'b1);
    cyc = 1;
    @(negedge clk);
    funct = 6'd18; rs_data = $urandom; rt_data = $urandom;
    #1;
    while (stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("mflo_stall_cycles", cyc, LAT);
    check("mflo_res_sel", res_sel, 2'b10);
    check("mflo_lo", lo, el);
    check("mflo_hi", hi, eh);
    m_hi = eh; m_lo = el;
    @(negedge clk);
    #1;
    check("mflo_no_restart", stall, 1'b0);
    valid = 1'b0;

    // ---------------- reset during MUL iteration 10 ----------------
    @(negedge clk);
    valid = 1'b1; aluOp = 2'b10; funct = 6'd25; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    #1;
    check("abort_busy_before", stall, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_stall", stall, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("abort_idle_after", stall, 1'b0);
    check("abort_hi_after", hi, 32'h0);
    run_op(25, 32'd3, 32'd4);
    check("post_abort_lo", lo, 32'd12);
    check("post_abort_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
